// File: rtl/block_b_arb_table_if.sv
// ---------------------------------------------------------------------------
// block_b_arb_table_if
//   Handshake bundle for block_b_arb_table: NUM_CH rdy/vld producer channels
//   on the write side, one first-word fall-through consumer on the read side.
//
//   Signals
//     in_vld   [NUM_CH]         per-channel valid           (producer -> table)
//     in_data  [NUM_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W]
//     in_rdy   [NUM_CH]         per-channel ready, one-hot or zero
//     out_vld                   head entry available         (table -> consumer)
//     out_data [DATA_W]         head entry payload
//     out_ch   [CH_W]           source channel of head entry
//     out_rdy                   consumer ready              (consumer -> table)
//
//   Modports
//     master : the producer/consumer side (testbench or surrounding logic)
//     slave  : the table itself
// ---------------------------------------------------------------------------
interface block_b_arb_table_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32
);
    localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        in_vld;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_rdy;
    logic                     out_vld;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_rdy;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_ch
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_ch
    );
endinterface

// File: rtl/block_b_arb_table.sv
// ---------------------------------------------------------------------------
// block_b_arb_table
//   Round-robin arbiter feeding a DEPTH-entry circular table. Each entry holds
//   the payload plus the channel it came from. The read side is first-word
//   fall-through. With overwrite_en set, a push into a full table (with no
//   simultaneous pop) replaces the oldest entry and bumps a saturating
//   drop counter.
//
//   Ports
//     clk           single clock, rising edge
//     rst_n         asynchronous, active-low reset
//     bus           block_b_arb_table_if.slave (producer/consumer handshakes)
//     overwrite_en  allow a push into a full table to drop the oldest entry
//     clear         synchronous flush of pointers, level and drop count
//     level         current entry count, 0..DEPTH
//     full / empty  level == DEPTH / level == 0
//     drop_cnt      number of overwritten entries, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module block_b_arb_table #(
    parameter  int NUM_CH = 3,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int CH_W   = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    block_b_arb_table_if.slave   bus,
    input  logic                 overwrite_en,
    input  logic                 clear,
    output logic [PTR_W:0]       level,
    output logic                 full,
    output logic                 empty,
    output logic [15:0]          drop_cnt
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]   rr_ptr;
    // Goes high on the first edge after reset release. Holding in_rdy low
    // until then guarantees no push lands on the deassertion edge.
    logic              active;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_ch;
    logic [DATA_W-1:0] gnt_data;
    logic [CH_W-1:0]   rr_next;
    logic              accept;
    logic              push;
    logic              pop;
    logic              drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first valid channel at or after rr_ptr, modulo NUM_CH.
    // The sum is one bit wider than CH_W so rr_ptr + i cannot overflow before
    // the modulo correction.
    always_comb begin
        logic [CH_W:0] cand;
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value held (which would infer a latch).
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!gnt_vld && bus.in_vld[cand[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch == CH_W'(i)) begin
                gnt_data = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_next = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;

    // Readiness deliberately ignores out_rdy: a full table without overwrite
    // only reopens on the cycle after a pop has lowered level.
    assign accept = active && !clear && (!full || overwrite_en);
    assign push   = gnt_vld && accept;
    assign pop    = !empty && bus.out_rdy;
    // A pop in the same cycle makes room, so only a lone push into a full
    // table counts as an overwrite.
    assign drop   = push && !pop && full;

    always_comb begin
        bus.in_rdy = '0;
        if (push) begin
            bus.in_rdy[gnt_ch] = 1'b1;
        end
    end

    assign full         = (level == (PTR_W+1)'(DEPTH));
    assign empty        = (level == '0);
    assign bus.out_vld  = !empty;
    assign bus.out_data = mem[rd_ptr].data;
    assign bus.out_ch   = mem[rd_ptr].ch;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            rr_ptr   <= '0;
            active   <= 1'b0;
        end else begin
            active <= 1'b1;
            if (clear) begin
                // rr_ptr is intentionally left alone so fairness survives a flush.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                drop_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                    rr_ptr <= rr_next;
                end
                // An overwrite discards the oldest entry, so the head moves too.
                if (pop || drop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (push && !pop && !full) begin
                    level <= level + 1'b1;
                end else if (pop && !push) begin
                    level <= level - 1'b1;
                end
                if (drop && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: the entry storage has no reset; contents are only observable
    // through rd_ptr while level is non-zero, and level is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{ch: gnt_ch, data: gnt_data};
        end
    end

endmodule
